cfg_reg_bank: RTL and testbench
===============================

CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
REQ-001 Parameter U_DLY, 1, register-assignment delay (ns) on every sequential assignment.
REQ-002 Parameter FPGA_VER, 32'h00000020, value returned at address 0.
REQ-003 Parameter REG_NUM, 64, number of 32-bit registers; legal range 4..256; register index equals address.
REQ-004 Parameter RST_VAL, all-zero, REG_NUM*32 bits; reset value of register i is RST_VAL[i*32+:32].
REQ-005 Parameter PULSE_MASK, all-zero, REG_NUM bits; a set bit marks register i as self-clearing.
REQ-006 Parameter SHADOW_MASK, all-zero, REG_NUM bits; a set bit marks register i as shadowed and committed via address 2.
REQ-007 Port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-008 Port rst_n  in  1  reset: rst_n, asynchronous, active-low.
REQ-009 Port inter_cfg_wr_en / inter_cfg_rd_en  in  1 each  host write / read strobe, single-cycle.
REQ-010 Port inter_cfg_addr  in  16  host address. Port inter_cfg_wr_data  in  32  host write data. Port inter_cfg_be  in  4  host byte enables.
REQ-011 Port inter_cfg_busy  out  1  pending host write outstanding.
REQ-012 Port inter_cfg_rd_data  out  32  read data. Port inter_cfg_rd_data_valid  out  1  read data qualifier.
REQ-013 Port init_cfg_wr_en  in  1, init_cfg_addr  in  16, init_cfg_data  in  32  initialisation write port; always full-word.
REQ-014 Port cfg_data  out  REG_NUM*32  active register values, flat. Port cfg_upd_stb  out  REG_NUM  per-register active-update pulse.
REQ-015 Port cfg_err  out  1  pulse on out-of-range access or dropped host write.

Function
REQ-016 Address map SHALL be: 0 read-only FPGA_VER (writes ignored); 1 test register, read returns bitwise inverse of stored value; 2 COMMIT, write with data[0]=1 triggers commit, reads return 0; 3..REG_NUM-1 general.
REQ-017 At most one write SHALL be applied per cycle, priority: init write > pending host write > new host write.
REQ-018 A new host write that cannot be applied SHALL be stored in a one-entry pending buffer (addr, data, be); inter_cfg_busy SHALL be 1 while the buffer is valid.
REQ-019 A new host write arriving while the pending buffer is valid and not draining SHALL be dropped, with cfg_err pulsing for one cycle; when the buffer drains in the same cycle, the new write SHALL take the buffer.
REQ-020 Byte lane k SHALL update only when inter_cfg_be[k]=1; be=4'b0000 is accepted with no register change and no cfg_upd_stb.
REQ-021 Write applied in cycle N SHALL be visible on cfg_data (non-shadow) and on reads from cycle N+1.
REQ-022 Shadowed registers SHALL write to a shadow copy only; cfg_data SHALL change only on commit.
REQ-023 Commit SHALL copy all shadow registers to active in the cycle after the COMMIT write is applied, using shadow contents at the end of the COMMIT-write cycle; a shadow write applied in the copy cycle updates only the shadow.
REQ-024 Pulse registers SHALL hold the written value on cfg_data for exactly one cycle, then return to RST_VAL.
REQ-025 cfg_upd_stb[i] SHALL pulse for one cycle, aligned with the first cycle the new active value appears, on any direct write or commit of register i; no pulse for address 0 or 2.
REQ-026 Reads SHALL have 1-cycle latency: rd_data_valid=1 in cycle N+1 for rd_en in cycle N; rd_data holds its value between reads.
REQ-027 Shadowed registers SHALL read the shadow value; a read and a write to the same address in one cycle SHALL return the pre-write value.
REQ-028 An address >= REG_NUM SHALL read 0, be ignored on write, and pulse cfg_err.

Reset
REQ-029 On rst_n low: active and shadow registers SHALL equal RST_VAL, pending buffer invalid, inter_cfg_busy=0, rd_data=0, rd_data_valid=0, cfg_upd_stb=0, cfg_err=0.
REQ-030 Reset mid-operation SHALL discard pending writes and any un-applied commit.

Verification
REQ-031 Write 0x12345678 to addr 5 with be=4'b0011; read addr 5 -> 0x00005678 with valid one cycle later, cfg_upd_stb[5] one pulse.
REQ-032 Init write to addr 3 and host write to addr 4 in the same cycle -> addr 3 applied at N+1, busy=1 for one cycle, addr 4 applied at N+2.
REQ-033 With SHADOW_MASK[6]=1, write 0xA5 to addr 6 -> cfg_data word 6 unchanged and read returns 0xA5; write 1 to addr 2 -> word 6=0xA5 one cycle later, cfg_upd_stb[6] pulses.
REQ-034 Three back-to-back host writes colliding with continuous init writes -> first held pending, second dropped, cfg_err=1 for one cycle.
REQ-035 Write 0x55AA55AA to addr 1 -> read returns 0xAA55AA55; read addr 0 -> FPGA_VER; read addr REG_NUM -> 0 with cfg_err pulse.
REQ-036 With PULSE_MASK[7]=1, write 0x1 to addr 7 -> cfg_data word 7 = 0x1 for exactly one cycle, then RST_VAL; assert rst_n low while busy=1 -> pending write never applied.

Source files
------------

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: host/init-writable 32-bit configuration register bank with
// a one-entry pending buffer for host writes, shadowed registers committed
// through address 2, self-clearing pulse registers and 1-cycle reads.
//
// Strobe semantics: inter_cfg_wr_en, inter_cfg_rd_en and init_cfg_wr_en are
// single-cycle strobes with no ready signal. An init write always wins the
// single write slot. A host write that cannot take the slot waits in the
// pending buffer (inter_cfg_busy=1). A host write that arrives while the
// buffer is full and not draining is dropped with a cfg_err pulse. Read data
// is qualified by inter_cfg_rd_data_valid one cycle after the read strobe.
module cfg_reg_bank #(
  parameter int                    U_DLY       = 1,
  parameter logic [31:0]           FPGA_VER    = 32'h0000_0020,
  parameter int                    REG_NUM     = 64,
  parameter logic [REG_NUM*32-1:0] RST_VAL     = '0,
  parameter logic [REG_NUM-1:0]    PULSE_MASK  = '0,
  parameter logic [REG_NUM-1:0]    SHADOW_MASK = '0
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    inter_cfg_wr_en,
  input  logic                    inter_cfg_rd_en,
  input  logic [15:0]             inter_cfg_addr,
  input  logic [31:0]             inter_cfg_wr_data,
  input  logic [3:0]              inter_cfg_be,
  output logic                    inter_cfg_busy,
  output logic [31:0]             inter_cfg_rd_data,
  output logic                    inter_cfg_rd_data_valid,
  input  logic                    init_cfg_wr_en,
  input  logic [15:0]             init_cfg_addr,
  input  logic [31:0]             init_cfg_data,
  output logic [REG_NUM*32-1:0]   cfg_data,
  output logic [REG_NUM-1:0]      cfg_upd_stb,
  output logic                    cfg_err
);

  localparam int          IW        = $clog2(REG_NUM);
  localparam logic [16:0] REG_NUM_W = 17'(REG_NUM);
  // Zero-delay RTL; the delay parameter is kept so existing instantiations still bind.
  localparam int          u_dly_unused = U_DLY;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    return r;
  endfunction

  logic [31:0]        active_q [REG_NUM];
  logic [31:0]        active_d [REG_NUM];
  logic [31:0]        shadow_q [REG_NUM];
  logic [31:0]        shadow_d [REG_NUM];
  logic               pend_valid_q, pend_valid_d;
  logic [15:0]        pend_addr_q, pend_addr_d;
  logic [31:0]        pend_data_q, pend_data_d;
  logic [3:0]         pend_be_q, pend_be_d;
  logic               commit_q, commit_d;
  logic [REG_NUM-1:0] upd_stb_q, upd_stb_d;
  logic               err_q, err_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic               host_in_range, init_in_range, host_ok, drop;
  logic               wr_valid, wr_in_range;
  logic [15:0]        wr_addr;
  logic [31:0]        wr_data;
  logic [3:0]         wr_be;
  logic [IW-1:0]      wr_idx, rd_idx;
  logic [31:0]        rd_stored, rd_word;

  assign host_in_range = ({1'b0, inter_cfg_addr} < REG_NUM_W);
  assign init_in_range = ({1'b0, init_cfg_addr} < REG_NUM_W);
  assign host_ok       = inter_cfg_wr_en & host_in_range;

  // Pick the one write applied this cycle and maintain the pending buffer.
  always_comb begin
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    wr_be        = '0;
    drop         = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_be_d    = pend_be_q;
    if (init_cfg_wr_en) begin
      wr_valid = 1'b1;
      wr_addr  = init_cfg_addr;
      wr_data  = init_cfg_data;
      wr_be    = 4'hF;
      if (host_ok) begin
        if (pend_valid_q) begin
          drop = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_addr_d  = inter_cfg_addr;
          pend_data_d  = inter_cfg_wr_data;
          pend_be_d    = inter_cfg_be;
        end
      end
    end else if (pend_valid_q) begin
      wr_valid     = 1'b1;
      wr_addr      = pend_addr_q;
      wr_data      = pend_data_q;
      wr_be        = pend_be_q;
      pend_valid_d = host_ok;
      if (host_ok) begin
        pend_addr_d = inter_cfg_addr;
        pend_data_d = inter_cfg_wr_data;
        pend_be_d   = inter_cfg_be;
      end
    end else if (host_ok) begin
      wr_valid = 1'b1;
      wr_addr  = inter_cfg_addr;
      wr_data  = inter_cfg_wr_data;
      wr_be    = inter_cfg_be;
    end
  end

  assign wr_in_range = ({1'b0, wr_addr} < REG_NUM_W);
  assign wr_idx      = wr_addr[IW-1:0];

  // Next register contents: pulse revert, commit copy, then the applied write.
  always_comb begin
    commit_d  = 1'b0;
    upd_stb_d = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      active_d[i] = PULSE_MASK[i] ? RST_VAL[i*32 +: 32] : active_q[i];
      shadow_d[i] = shadow_q[i];
    end
    if (commit_q) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (SHADOW_MASK[i]) begin
          active_d[i]  = shadow_q[i];
          upd_stb_d[i] = 1'b1;
        end
      end
    end
    if (wr_valid && wr_in_range && (wr_be != 4'b0000)) begin
      if (wr_idx == IW'(2)) begin
        commit_d = wr_be[0] & wr_data[0];
      end else if (wr_idx != '0) begin
        if (SHADOW_MASK[wr_idx]) begin
          shadow_d[wr_idx] = merge_be(shadow_q[wr_idx], wr_data, wr_be);
        end else begin
          active_d[wr_idx]  = merge_be(active_q[wr_idx], wr_data, wr_be);
          upd_stb_d[wr_idx] = 1'b1;
        end
      end
    end
  end

  // Read mux on pre-write state, error pulse sources.
  always_comb begin
    rd_idx    = inter_cfg_addr[IW-1:0];
    rd_stored = SHADOW_MASK[rd_idx] ? shadow_q[rd_idx] : active_q[rd_idx];
    rd_word   = '0;
    if (!host_in_range)            rd_word = '0;
    else if (rd_idx == '0)         rd_word = FPGA_VER;
    else if (rd_idx == IW'(1))     rd_word = ~rd_stored;
    else if (rd_idx == IW'(2))     rd_word = '0;
    else                           rd_word = rd_stored;
    rd_data_d  = inter_cfg_rd_en ? rd_word : rd_data_q;
    rd_valid_d = inter_cfg_rd_en;
    err_d      = (inter_cfg_wr_en & ~host_in_range) |
                 (inter_cfg_rd_en & ~host_in_range) |
                 (init_cfg_wr_en  & ~init_in_range) | drop;
  end

  // Flatten the active registers onto cfg_data.
  always_comb begin
    cfg_data = '0;
    for (int i = 0; i < REG_NUM; i++) cfg_data[i*32 +: 32] = active_q[i];
  end

  // State registers; reset drops pending writes and any queued commit.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        active_q[i] <= RST_VAL[i*32 +: 32];
        shadow_q[i] <= RST_VAL[i*32 +: 32];
      end
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_be_q    <= '0;
      commit_q     <= 1'b0;
      upd_stb_q    <= '0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_be_q    <= pend_be_d;
      commit_q     <= commit_d;
      upd_stb_q    <= upd_stb_d;
      err_q        <= err_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign inter_cfg_busy          = pend_valid_q;
  assign inter_cfg_rd_data       = rd_data_q;
  assign inter_cfg_rd_data_valid = rd_valid_q;
  assign cfg_upd_stb             = upd_stb_q;
  assign cfg_err                 = err_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank: directed scenarios plus randomized traffic, every cycle
// compared against a queue/array reference model of the register bank.
module tb_cfg_reg_bank;

  localparam int          N   = 64;
  localparam logic [31:0] VER = 32'h0000_0020;

  function automatic logic [N*32-1:0] mk_rst();
    logic [N*32-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (i % 3 == 1) r[i*32 +: 32] = 32'h5A00_0000 | 32'(i);
    return r;
  endfunction

  localparam logic [N*32-1:0] RST   = mk_rst();
  localparam logic [N-1:0]    PMASK = (64'd1 << 7) | (64'd1 << 10);
  localparam logic [N-1:0]    SMASK = (64'd1 << 6) | (64'd1 << 9) | (64'd1 << 12);

  // clock / reset
  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic           wr_en, rd_en, init_en;
  logic [15:0]    addr, init_addr;
  logic [31:0]    wdata, init_data;
  logic [3:0]     be;
  logic           busy, rd_valid, err;
  logic [31:0]    rd_data;
  logic [N*32-1:0] cfg_data;
  logic [N-1:0]   upd_stb;

  cfg_reg_bank #(
    .U_DLY(1), .FPGA_VER(VER), .REG_NUM(N), .RST_VAL(RST),
    .PULSE_MASK(PMASK), .SHADOW_MASK(SMASK)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .inter_cfg_wr_en(wr_en), .inter_cfg_rd_en(rd_en),
    .inter_cfg_addr(addr), .inter_cfg_wr_data(wdata), .inter_cfg_be(be),
    .inter_cfg_busy(busy), .inter_cfg_rd_data(rd_data),
    .inter_cfg_rd_data_valid(rd_valid),
    .init_cfg_wr_en(init_en), .init_cfg_addr(init_addr), .init_cfg_data(init_data),
    .cfg_data(cfg_data), .cfg_upd_stb(upd_stb), .cfg_err(err)
  );

  // scoreboard counters
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  typedef struct packed { logic [15:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  logic [31:0] m_act [N];
  logic [31:0] m_shd [N];
  wr_t         m_pend [$];
  bit          m_commit;
  logic [31:0] m_rd;
  bit          m_rdv, m_err;
  logic [N-1:0] m_stb;

  function automatic logic [31:0] rst_word(input int i);
    logic [N*32-1:0] r;
    r = RST;
    return r[i*32 +: 32];
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = rst_word(i);
      m_shd[i] = rst_word(i);
    end
    m_pend.delete();
    m_commit = 0; m_rd = '0; m_rdv = 0; m_err = 0; m_stb = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [31:0] v;
    if (a >= N) return 32'h0;
    if (a == 0) return VER;
    if (a == 2) return 32'h0;
    v = SMASK[a] ? m_shd[a] : m_act[a];
    return (a == 1) ? ~v : v;
  endfunction

  task automatic model_update();
    logic [31:0] nxt [N];
    logic [31:0] rv;
    wr_t  w, host;
    bit   have_w, host_ok, new_commit;
    rv = model_read(addr);
    m_err = (wr_en && addr >= N) || (rd_en && addr >= N) || (init_en && init_addr >= N);
    host_ok = wr_en && (addr < N);
    host = '{a: addr, d: wdata, be: be};
    have_w = 0;
    w = '0;
    if (init_en) begin
      w = '{a: init_addr, d: init_data, be: 4'hF};
      have_w = (init_addr < N);
      if (host_ok) begin
        if (m_pend.size() != 0) m_err = 1;
        else m_pend.push_back(host);
      end
    end else if (m_pend.size() != 0) begin
      w = m_pend.pop_front();
      have_w = 1;
      if (host_ok) m_pend.push_back(host);
    end else if (host_ok) begin
      w = host;
      have_w = 1;
    end
    m_stb = '0;
    for (int i = 0; i < N; i++) nxt[i] = PMASK[i] ? rst_word(i) : m_act[i];
    if (m_commit)
      for (int i = 0; i < N; i++)
        if (SMASK[i]) begin nxt[i] = m_shd[i]; m_stb[i] = 1'b1; end
    new_commit = 0;
    if (have_w && w.be != 4'b0000) begin
      if (w.a == 2) new_commit = w.be[0] && w.d[0];
      else if (w.a != 0) begin
        if (SMASK[w.a]) m_shd[w.a] = mrg(m_shd[w.a], w.d, w.be);
        else begin nxt[w.a] = mrg(m_act[w.a], w.d, w.be); m_stb[w.a] = 1'b1; end
      end
    end
    m_commit = new_commit;
    for (int i = 0; i < N; i++) m_act[i] = nxt[i];
    m_rdv = rd_en;
    if (rd_en) m_rd = rv;
  endtask

  task automatic compare_all();
    chk("busy", 64'(busy), 64'(m_pend.size() != 0));
    chk("err", 64'(err), 64'(m_err));
    chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("upd_stb", 64'(upd_stb), 64'(m_stb));
    for (int i = 0; i < N; i++)
      chk($sformatf("cfg_data[%0d]", i), 64'(cfg_data[i*32 +: 32]), 64'(m_act[i]));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_sys);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic drive(input bit ie, input logic [15:0] ia, input logic [31:0] id,
                       input bit we, input bit re, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    init_en = ie; init_addr = ia; init_data = id;
    wr_en = we; rd_en = re; addr = a; wdata = d; be = b;
    step();
  endtask

  task automatic idle();
    drive(0, 16'd0, 32'd0, 0, 0, 16'd0, 32'd0, 4'h0);
  endtask

  function automatic logic [31:0] word(input int i);
    return cfg_data[i*32 +: 32];
  endfunction

  logic [15:0] picks [8] = '{16'd0, 16'd1, 16'd2, 16'd6, 16'd7, 16'd9, 16'd10, 16'd12};

  initial begin
    init_en = 0; init_addr = '0; init_data = '0;
    wr_en = 0; rd_en = 0; addr = '0; wdata = '0; be = '0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    compare_all();
    chk("reset_word1", 64'(word(1)), 64'(32'h5A00_0001));
    @(negedge clk_sys) rst_n = 1'b1;

    // partial byte-enable write then read
    drive(0, 0, 0, 1, 0, 16'd5, 32'h1234_5678, 4'b0011);
    chk("w5_stb", 64'(upd_stb[5]), 64'd1);
    drive(0, 0, 0, 0, 1, 16'd5, 32'h0, 4'h0);
    chk("r5_data", 64'(rd_data), 64'h0000_5678);
    chk("r5_valid", 64'(rd_valid), 64'd1);
    chk("r5_stb_gone", 64'(upd_stb[5]), 64'd0);
    idle();
    chk("rd_valid_drop", 64'(rd_valid), 64'd0);

    // init write and host write collide
    drive(1, 16'd3, 32'hCAFE_0003, 1, 0, 16'd4, 32'hBEEF_0004, 4'hF);
    chk("col_busy1", 64'(busy), 64'd1);
    chk("col_w3", 64'(word(3)), 64'hCAFE_0003);
    chk("col_w4_old", 64'(word(4)), 64'h5A00_0004);
    idle();
    chk("col_busy0", 64'(busy), 64'd0);
    chk("col_w4_new", 64'(word(4)), 64'hBEEF_0004);

    // shadow write, read-back, commit
    drive(0, 0, 0, 1, 0, 16'd6, 32'h0000_00A5, 4'hF);
    chk("sh_w6_hold", 64'(word(6)), 64'h0);
    chk("sh_no_stb", 64'(upd_stb[6]), 64'd0);
    drive(0, 0, 0, 0, 1, 16'd6, 32'h0, 4'h0);
    chk("sh_rd6", 64'(rd_data), 64'h0000_00A5);
    drive(0, 0, 0, 1, 0, 16'd2, 32'h1, 4'hF);
    chk("sh_w6_pre", 64'(word(6)), 64'h0);
    idle();
    chk("sh_w6_commit", 64'(word(6)), 64'h0000_00A5);
    chk("sh_stb6", 64'(upd_stb[6]), 64'd1);

    // back-to-back host writes against init writes
    drive(1, 16'd20, 32'h1111_0020, 1, 0, 16'd8, 32'hAAAA_0008, 4'hF);
    drive(1, 16'd21, 32'h1111_0021, 1, 0, 16'd11, 32'hBBBB_000B, 4'hF);
    chk("drop_err", 64'(err), 64'd1);
    drive(0, 0, 0, 1, 0, 16'd13, 32'hCCCC_000D, 4'hF);
    chk("drop_err_once", 64'(err), 64'd0);
    chk("drop_w8", 64'(word(8)), 64'hAAAA_0008);
    idle();
    chk("drop_w11", 64'(word(11)), 64'h0);
    chk("drop_w13", 64'(word(13)), 64'hCCCC_000D);

    // test register, version, out of range
    drive(0, 0, 0, 1, 0, 16'd1, 32'h55AA_55AA, 4'hF);
    drive(0, 0, 0, 0, 1, 16'd1, 32'h0, 4'h0);
    chk("rd_inv", 64'(rd_data), 64'hAA55_AA55);
    drive(0, 0, 0, 0, 1, 16'd0, 32'h0, 4'h0);
    chk("rd_ver", 64'(rd_data), 64'(VER));
    drive(0, 0, 0, 0, 1, 16'(N), 32'h0, 4'h0);
    chk("rd_oor", 64'(rd_data), 64'h0);
    chk("rd_oor_err", 64'(err), 64'd1);

    // pulse register
    drive(0, 0, 0, 1, 0, 16'd7, 32'h1, 4'hF);
    chk("pulse_on", 64'(word(7)), 64'h1);
    idle();
    chk("pulse_off", 64'(word(7)), 64'h5A00_0007);

    // reset while a host write is pending
    drive(1, 16'd3, 32'h0, 1, 0, 16'd5, 32'hFFFF_FFFF, 4'hF);
    chk("rst_busy_pre", 64'(busy), 64'd1);
    init_en = 0; wr_en = 0; rd_en = 0; be = '0;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys) rst_n = 1'b1;
    repeat (3) idle();
    chk("rst_no_apply", 64'(word(5)), 64'h0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      logic [15:0] a, ia;
      a  = ($urandom_range(0, 2) != 0) ? picks[$urandom_range(0, 7)] : 16'($urandom_range(0, N + 5));
      ia = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(N, N + 5)) : 16'($urandom_range(1, N - 1));
      drive($urandom_range(0, 2) == 0, ia, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom,
            ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
    end
    repeat (3) idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
